// File: rtl/led_pattern_gen.sv
// led_pattern_gen: prescaled multi-channel LED pattern driver with global PWM brightness.
// Ports: clk, rst (sync, active-high), mode[1:0], duty[pwm_bits-1:0] in; tick, leds[num_leds-1:0] out.
module led_pattern_gen #(
   parameter int clk_freq_hz = 50000000,
   parameter int tick_hz     = 8,
   parameter int num_leds    = 8,
   parameter int pwm_bits    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          mode,
   input  logic [pwm_bits-1:0] duty,
   output logic                tick,
   output logic [num_leds-1:0] leds
);

   localparam int div   = clk_freq_hz / tick_hz;
   localparam int cnt_w = (div < 2) ? 1 : $clog2(div);
   localparam logic [cnt_w-1:0] cnt_last = cnt_w'(div - 1);

   localparam logic [1:0] mode_blink = 2'd0;
   localparam logic [1:0] mode_count = 2'd1;
   localparam logic [1:0] mode_chase = 2'd2;
   localparam logic [1:0] mode_off   = 2'd3;

   localparam logic dir_up = 1'b0;
   localparam logic dir_dn = 1'b1;

   if (div < 2) begin : g_div_chk
      $error("led_pattern_gen: clk_freq_hz/tick_hz must be >= 2");
   end

   logic [cnt_w-1:0]    tick_cnt;
   logic [pwm_bits-1:0] pwm_cnt;
   logic [1:0]          mode_q;
   logic [num_leds-1:0] pattern;
   logic                dir;

   logic                step;
   logic                mode_chg;
   logic                pwm_on;
   logic [num_leds-1:0] pat_init;
   logic [num_leds-1:0] pat_nxt;
   logic                dir_nxt;
   logic [num_leds-1:0] leds_nxt;

   assign step     = (tick_cnt == cnt_last);
   assign mode_chg = (mode != mode_q);

   // Pattern loaded on reset and on every mode change.
   always_comb begin
      pat_init = '0;
      if (mode == mode_chase) pat_init[0] = 1'b1;
   end

   // Next pattern value for a step; selected by the mode that owns the pattern.
   always_comb begin
      pat_nxt = pattern;
      dir_nxt = dir;
      unique case (mode_q)
         mode_blink: pat_nxt = ~pattern;
         mode_count: pat_nxt = pattern + num_leds'(1);
         mode_chase: begin
            if (num_leds == 1) begin
               pat_nxt = pattern;
            end else if (dir == dir_up) begin
               if (pattern[num_leds-1]) begin
                  dir_nxt = dir_dn;
                  pat_nxt = pattern >> 1;
               end else begin
                  pat_nxt = pattern << 1;
               end
            end else begin
               if (pattern[0]) begin
                  dir_nxt = dir_up;
                  pat_nxt = pattern << 1;
               end else begin
                  pat_nxt = pattern >> 1;
               end
            end
         end
         mode_off: pat_nxt = '0;
         default:  pat_nxt = '0;
      endcase
   end

   // All-ones duty must be fully on, which pwm_cnt < duty alone never reaches.
   always_comb begin
      pwm_on   = (duty == '1) | (pwm_cnt < duty);
      leds_nxt = pattern & {num_leds{pwm_on}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt <= '0;
         pwm_cnt  <= '0;
         tick     <= 1'b0;
         leds     <= '0;
         dir      <= dir_up;
         mode_q   <= mode;
         pattern  <= pat_init;
      end else begin
         mode_q  <= mode;
         pwm_cnt <= pwm_cnt + pwm_bits'(1);
         leds    <= leds_nxt;
         if (mode_chg) begin
            // A mode change restarts the step period and suppresses any step.
            pattern  <= pat_init;
            dir      <= dir_up;
            tick_cnt <= '0;
            tick     <= 1'b0;
         end else begin
            tick <= step;
            if (step) begin
               tick_cnt <= '0;
               pattern  <= pat_nxt;
               dir      <= dir_nxt;
            end else begin
               tick_cnt <= tick_cnt + cnt_w'(1);
            end
         end
      end
   end

endmodule
